// File: rtl/tnoc_config_pkg.sv
// rtl/tnoc_config_pkg.sv - NoC-wide configuration record shared by tnoc blocks
package tnoc_config_pkg;

  typedef struct packed {
    int unsigned address_width;
    int unsigned data_width;
    int unsigned virtual_channels;
    int unsigned max_flit_sources;
  } tnoc_config;

  localparam tnoc_config TNOC_DEFAULT_CONFIG = '{
    address_width:    32,
    data_width:       32,
    virtual_channels: 2,
    max_flit_sources: 16
  };

endpackage

// File: rtl/tnoc_flit_if_arbiter_pkg.sv
// rtl/tnoc_flit_if_arbiter_pkg.sv - local types and helpers for the flit-interface arbiter
package tnoc_flit_if_arbiter_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } tnoc_arb_state_e;

  // Pointer width; a single-entry arbiter still carries a 1-bit pointer held at 0.
  function automatic int ptr_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/tnoc_rr_priority_select.sv
// rtl/tnoc_rr_priority_select.sv - round-robin winner pick from a priority pointer
module tnoc_rr_priority_select #(
  parameter int ENTRIES = 2,
  parameter int PTR_W   = 1
) (
  input  logic [ENTRIES-1:0] i_request,
  input  logic [PTR_W-1:0]   i_pointer,
  output logic [ENTRIES-1:0] o_winner,
  output logic               o_has_winner
);

  logic [2*ENTRIES-1:0] doubled;
  logic [ENTRIES-1:0]   rotated;

  // Rotating the doubled vector puts the pointer entry at bit 0, so a plain
  // find-first-set walks the entries in round-robin order.
  assign doubled = {i_request, i_request};
  assign rotated = ENTRIES'(doubled >> i_pointer);

  // First set bit of the rotated vector, mapped back to an absolute index.
  always_comb begin
    logic found;
    int   pos;
    found    = 1'b0;
    pos      = 0;
    o_winner = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (rotated[i] && !found) begin
        found = 1'b1;
        pos   = int'(i_pointer) + i;
        if (pos >= ENTRIES) begin
          pos = pos - ENTRIES;
        end
      end
    end
    for (int j = 0; j < ENTRIES; j++) begin
      o_winner[j] = found && (pos == j);
    end
    o_has_winner = found;
  end

endmodule

// File: rtl/tnoc_flit_if_arbiter.sv
// rtl/tnoc_flit_if_arbiter.sv - packet-locked round-robin select for a shared flit link
module tnoc_flit_if_arbiter
  import tnoc_config_pkg::*;
  import tnoc_flit_if_arbiter_pkg::*;
#(
  parameter tnoc_config CONFIG  = TNOC_DEFAULT_CONFIG,
  parameter int         ENTRIES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ENTRIES-1:0] i_request,
  input  logic               i_out_valid,
  input  logic               i_out_ready,
  input  logic               i_out_tail,
  output logic [ENTRIES-1:0] o_grant,
  output logic               o_busy
);

  localparam int PTR_W = ptr_width(ENTRIES);

  if ((ENTRIES < 1) || (ENTRIES > int'(CONFIG.max_flit_sources))) begin : g_illegal_entries
    $error("tnoc_flit_if_arbiter: ENTRIES out of range");
  end

  tnoc_arb_state_e    state;
  logic [ENTRIES-1:0] grant_q;
  logic               busy_q;
  logic [PTR_W-1:0]   ptr_q;

  logic               free;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   sel_ptr;
  logic [ENTRIES-1:0] sel_winner;
  logic               sel_has_winner;

  // The locked packet ends only when its tail is actually taken downstream.
  assign free = i_out_valid & i_out_ready & i_out_tail;

  // Index of the currently held grant, used to move the pointer past it.
  always_comb begin
    grant_idx = '0;
    for (int j = 0; j < ENTRIES; j++) begin
      if (grant_q[j]) begin
        grant_idx = PTR_W'(j);
      end
    end
  end

  assign next_ptr = (grant_idx == PTR_W'(ENTRIES - 1)) ? '0 : grant_idx + PTR_W'(1);

  // While locked the only selection that matters is the regrant at tail
  // accept, which must already see the advanced pointer.
  assign sel_ptr = (state == LOCKED) ? next_ptr : ptr_q;

  tnoc_rr_priority_select #(
    .ENTRIES (ENTRIES),
    .PTR_W   (PTR_W)
  ) u_select (
    .i_request    (i_request),
    .i_pointer    (sel_ptr),
    .o_winner     (sel_winner),
    .o_has_winner (sel_has_winner)
  );

  // Lock FSM: grant on request from IDLE, hold until tail accept, then regrant or release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_has_winner) begin
            grant_q <= sel_winner;
            busy_q  <= 1'b1;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          if (free) begin
            ptr_q <= next_ptr;
            if (sel_has_winner) begin
              grant_q <= sel_winner;
            end else begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_tnoc_flit_if_arbiter.sv
// tb/tb_tnoc_flit_if_arbiter.sv - bench for the packet-locked flit-interface arbiter
module tb_tnoc_flit_if_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [3:0] req4   = '0;
  logic       valid4 = 1'b0;
  logic       ready4 = 1'b0;
  logic       tail4  = 1'b0;
  logic [3:0] g4;
  logic       busy4;

  logic [0:0] req1   = '0;
  logic       valid1 = 1'b0;
  logic       ready1 = 1'b0;
  logic       tail1  = 1'b0;
  logic [0:0] g1;
  logic       busy1;

  int n_checks = 0;
  int n_fail   = 0;

  bit m4_locked = 1'b0;
  int m4_owner  = 0;
  int m4_ptr    = 0;
  bit m1_locked = 1'b0;
  int m1_owner  = 0;
  int m1_ptr    = 0;

  logic [3:0] rr_exp [4];

  always #5 clk = ~clk;

  tnoc_flit_if_arbiter #(.ENTRIES(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .i_request   (req4),
    .i_out_valid (valid4),
    .i_out_ready (ready4),
    .i_out_tail  (tail4),
    .o_grant     (g4),
    .o_busy      (busy4)
  );

  tnoc_flit_if_arbiter #(.ENTRIES(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .i_request   (req1),
    .i_out_valid (valid1),
    .i_out_ready (ready1),
    .i_out_tail  (tail1),
    .o_grant     (g1),
    .o_busy      (busy1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: who owns the link and where round-robin resumes, from the rules.
  task automatic model_step(input int n, input logic [15:0] req, input bit fr, input bit r,
                            inout bit locked, inout int owner, inout int ptr);
    if (r) begin
      locked = 1'b0;
      owner  = 0;
      ptr    = 0;
      return;
    end
    if (locked) begin
      if (!fr) return;
      ptr    = (owner + 1) % n;
      locked = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      if (req[(ptr + k) % n]) begin
        locked = 1'b1;
        owner  = (ptr + k) % n;
        return;
      end
    end
  endtask

  // One clock: advance the models with the inputs present at the edge, then check.
  task automatic step();
    bit         f4;
    bit         f1;
    bit         hold4;
    bit         hold1;
    logic [3:0] pre4;
    logic [0:0] pre1;
    logic [15:0] e4;
    logic [15:0] e1;
    f4    = valid4 & ready4 & tail4;
    f1    = valid1 & ready1 & tail1;
    hold4 = (busy4 === 1'b1) && !f4 && !rst;
    hold1 = (busy1 === 1'b1) && !f1 && !rst;
    pre4  = g4;
    pre1  = g1;
    model_step(4, {12'b0, req4}, f4, rst, m4_locked, m4_owner, m4_ptr);
    model_step(1, {15'b0, req1}, f1, rst, m1_locked, m1_owner, m1_ptr);
    @(posedge clk);
    #1;
    e4 = m4_locked ? (16'd1 << m4_owner) : 16'd0;
    e1 = m1_locked ? (16'd1 << m1_owner) : 16'd0;
    check("model_grant4", {12'b0, g4}, e4);
    check("model_busy4", {15'b0, busy4}, {15'b0, m4_locked});
    check("busy_eq_or4", {15'b0, busy4}, {15'b0, |g4});
    check("onehot0_4", {15'b0, $onehot0(g4)}, 16'd1);
    if (hold4) check("stable_locked4", {12'b0, g4}, {12'b0, pre4});
    check("model_grant1", {15'b0, g1}, e1);
    check("busy_eq_or1", {15'b0, busy1}, {15'b0, |g1});
    if (hold1) check("stable_locked1", {15'b0, g1}, {15'b0, pre1});
    @(negedge clk);
  endtask

  initial begin
    rr_exp[0] = 4'b0010;
    rr_exp[1] = 4'b0100;
    rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001;
    @(negedge clk);

    // reset with entry 2 requesting, then 1-cycle grant latency
    rst = 1'b1; req4 = 4'b0100;
    step();
    check("reset_grant", {12'b0, g4}, 16'h0);
    check("reset_busy", {15'b0, busy4}, 16'h0);
    rst = 1'b0;
    step();
    check("first_grant", {12'b0, g4}, 16'h4);
    check("first_busy", {15'b0, busy4}, 16'h1);

    // lock hold across a 3-flit packet while other requests churn
    req4 = 4'b1011; valid4 = 1'b1; ready4 = 1'b1; tail4 = 1'b0;
    step();
    check("hold_flit1", {12'b0, g4}, 16'h4);
    step();
    check("hold_flit2", {12'b0, g4}, 16'h4);
    tail4 = 1'b1; ready4 = 1'b0;
    step();
    check("tail_not_ready", {12'b0, g4}, 16'h4);
    ready4 = 1'b1;
    step();
    check("regrant_after_tail", {12'b0, g4}, 16'h8);

    // round-robin with single-flit packets every cycle
    rst = 1'b1; req4 = 4'b1111; valid4 = 1'b0; ready4 = 1'b0; tail4 = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("rr_first", {12'b0, g4}, 16'h1);
    valid4 = 1'b1; ready4 = 1'b1; tail4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_seq", {12'b0, g4}, {12'b0, rr_exp[i]});
    end

    // sole requester: two 2-flit packets with no bubble, release after last tail
    rst = 1'b1; req4 = 4'b0010; valid4 = 1'b0; ready4 = 1'b0; tail4 = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("sole_grant", {12'b0, g4}, 16'h2);
    valid4 = 1'b1; ready4 = 1'b1; tail4 = 1'b0;
    step();
    tail4 = 1'b1;
    step();
    check("sole_no_bubble", {12'b0, g4}, 16'h2);
    tail4 = 1'b0;
    step();
    check("sole_pkt2", {12'b0, g4}, 16'h2);
    tail4 = 1'b1; req4 = 4'b0000;
    step();
    check("sole_release", {12'b0, g4}, 16'h0);
    check("sole_release_busy", {15'b0, busy4}, 16'h0);

    // reset while locked on entry 3 drops the lock and resets priority
    req4 = 4'b1000; valid4 = 1'b0; ready4 = 1'b0; tail4 = 1'b0;
    step();
    check("lock_e3", {12'b0, g4}, 16'h8);
    rst = 1'b1;
    step();
    check("midpkt_rst_grant", {12'b0, g4}, 16'h0);
    check("midpkt_rst_busy", {15'b0, busy4}, 16'h0);
    rst = 1'b0; req4 = 4'b1001;
    step();
    check("post_rst_grant", {12'b0, g4}, 16'h1);

    // tail accept seen while idle leaves the pointer alone
    rst = 1'b1; req4 = 4'b0000;
    step();
    rst = 1'b0; valid4 = 1'b1; ready4 = 1'b1; tail4 = 1'b1;
    step();
    check("idle_free_nogrant", {12'b0, g4}, 16'h0);
    req4 = 4'b1111; valid4 = 1'b0;
    step();
    check("idle_free_ignored", {12'b0, g4}, 16'h1);

    // single-entry arbiter with a 2-flit packet
    req4 = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0; req1 = 1'b1;
    step();
    check("e1_grant", {15'b0, g1}, 16'h1);
    check("e1_busy", {15'b0, busy1}, 16'h1);
    valid1 = 1'b1; ready1 = 1'b1; tail1 = 1'b0;
    step();
    check("e1_hold", {15'b0, g1}, 16'h1);
    tail1 = 1'b1; req1 = 1'b0;
    step();
    check("e1_release", {15'b0, g1}, 16'h0);

    // randomized traffic against the reference model
    for (int c = 0; c < 500; c++) begin
      rst    = ($urandom_range(0, 63) == 0);
      req4   = 4'($urandom);
      valid4 = ($urandom_range(0, 3) != 0);
      ready4 = ($urandom_range(0, 3) != 0);
      tail4  = ($urandom_range(0, 2) == 0);
      req1   = 1'($urandom);
      valid1 = ($urandom_range(0, 3) != 0);
      ready1 = ($urandom_range(0, 1) != 0);
      tail1  = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
